// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, zero-register constant and priority-state type
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef enum logic {
    PREFER0 = 1'b0,
    PREFER1 = 1'b1
  } prio_e;

endpackage

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter
// Alternating-priority grant, one-cycle registered write port, saturating conflict counter.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              reqValid0,
  input  logic [ADDR_W-1:0] reqAddr0,
  input  logic [DATA_W-1:0] reqData0,
  output logic              reqReady0,
  input  logic              reqValid1,
  input  logic [ADDR_W-1:0] reqAddr1,
  input  logic [DATA_W-1:0] reqData1,
  output logic              reqReady1,
  input  logic              stall,
  output logic              wrEnable,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic [CNT_W-1:0]  conflictCount
);

  prio_e             prioState;
  logic              xfer;
  logic              contended;
  logic [ADDR_W-1:0] grantAddr;
  logic [DATA_W-1:0] grantData;

  // Grants depend only on valids, stall, reset and priority; never on address or data.
  always_comb begin
    reqReady0 = 1'b0;
    reqReady1 = 1'b0;
    if (resetN && !stall) begin
      if (reqValid0 && (!reqValid1 || prioState == PREFER0)) begin
        reqReady0 = 1'b1;
      end else if (reqValid1) begin
        reqReady1 = 1'b1;
      end
    end
  end

  assign xfer      = reqReady0 | reqReady1;
  assign contended = !stall && reqValid0 && reqValid1;
  assign grantAddr = reqReady1 ? reqAddr1 : reqAddr0;
  assign grantData = reqReady1 ? reqData1 : reqData0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prioState     <= PREFER0;
      wrEnable      <= 1'b0;
      wrAddr        <= '0;
      wrData        <= '0;
      conflictCount <= '0;
    end else begin
      // Writes to the zero register are accepted and latched but never strobed.
      wrEnable <= xfer && (grantAddr != ADDR_W'(ZERO_REG));
      if (xfer) begin
        wrAddr    <= grantAddr;
        wrData    <= grantData;
        prioState <= reqReady0 ? PREFER1 : PREFER0;
      end
      if (contended && conflictCount != {CNT_W{1'b1}}) begin
        conflictCount <= conflictCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        reqValid0, reqValid1, stall;
  logic [4:0]  reqAddr0, reqAddr1;
  logic [63:0] reqData0, reqData1;

  logic        reqReady0, reqReady1, wrEnable;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic [15:0] conflictCount;

  logic        reqReady0S, reqReady1S, wrEnableS;
  logic [4:0]  wrAddrS;
  logic [63:0] wrDataS;
  logic [1:0]  conflictCountS;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .resetN(resetN),
    .reqValid0(reqValid0), .reqAddr0(reqAddr0), .reqData0(reqData0), .reqReady0(reqReady0),
    .reqValid1(reqValid1), .reqAddr1(reqAddr1), .reqData1(reqData1), .reqReady1(reqReady1),
    .stall(stall), .wrEnable(wrEnable), .wrAddr(wrAddr), .wrData(wrData),
    .conflictCount(conflictCount)
  );

  regfile_write_arbiter #(.CNT_W(2)) dutSmall (
    .clk(clk), .resetN(resetN),
    .reqValid0(reqValid0), .reqAddr0(reqAddr0), .reqData0(reqData0), .reqReady0(reqReady0S),
    .reqValid1(reqValid1), .reqAddr1(reqAddr1), .reqData1(reqData1), .reqReady1(reqReady1S),
    .stall(stall), .wrEnable(wrEnableS), .wrAddr(wrAddrS), .wrData(wrDataS),
    .conflictCount(conflictCountS)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; stall = 1'b0;
    reqValid0 = 1'b1; reqAddr0 = 5'd9; reqData0 = 64'h55;
    reqValid1 = 1'b1; reqAddr1 = 5'd8; reqData1 = 64'h66;
    step();
    chk("rst_ready0", reqReady0, 1'b0);
    chk("rst_ready1", reqReady1, 1'b0);
    chk("rst_wrEnable", wrEnable, 1'b0);
    chk("rst_wrAddr", wrAddr, 5'd0);
    chk("rst_wrData", wrData, 64'd0);
    chk("rst_count", conflictCount, 16'd0);

    // Single requester 0 right after release
    resetN = 1'b1;
    reqValid1 = 1'b0; reqAddr0 = 5'd3; reqData0 = 64'h1;
    #1;
    chk("single0_ready0", reqReady0, 1'b1);
    chk("single0_ready1", reqReady1, 1'b0);
    step();
    reqValid0 = 1'b0;
    chk("single0_wrEnable", wrEnable, 1'b1);
    chk("single0_wrAddr", wrAddr, 5'd3);
    chk("single0_wrData", wrData, 64'h1);

    // Requester 1 alone to the zero register; priority is PREFER1 now, moves back to PREFER0
    reqValid1 = 1'b1; reqAddr1 = 5'd31; reqData1 = 64'hFFFF;
    #1;
    chk("zero_ready1", reqReady1, 1'b1);
    chk("zero_ready0", reqReady0, 1'b0);
    step();
    reqValid1 = 1'b0;
    chk("zero_wrEnable", wrEnable, 1'b0);
    chk("zero_wrAddr", wrAddr, 5'd31);
    chk("zero_wrData", wrData, 64'hFFFF);

    // Idle cycle: outputs hold, no strobe
    step();
    chk("idle_wrEnable", wrEnable, 1'b0);
    chk("idle_wrAddr", wrAddr, 5'd31);
    chk("idle_wrData", wrData, 64'hFFFF);

    // Both valid for four cycles: grants alternate 0,1,0,1
    reqValid0 = 1'b1; reqAddr0 = 5'd1; reqData0 = 64'hA;
    reqValid1 = 1'b1; reqAddr1 = 5'd2; reqData1 = 64'hB;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk($sformatf("alt%0d_ready0", k), reqReady0, (k % 2) == 1);
      chk($sformatf("alt%0d_ready1", k), reqReady1, (k % 2) == 0);
      step();
      chk($sformatf("alt%0d_wrEnable", k), wrEnable, 1'b1);
      chk($sformatf("alt%0d_wrAddr", k), wrAddr, (k % 2) == 1 ? 5'd1 : 5'd2);
      chk($sformatf("alt%0d_wrData", k), wrData, (k % 2) == 1 ? 64'hA : 64'hB);
      chk($sformatf("alt%0d_count", k), conflictCount, k);
      chk($sformatf("alt%0d_countSat", k), conflictCountS, k > 3 ? 3 : k);
    end

    // Stall with both valid: nothing granted, counters and priority hold
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("stall%0d_ready0", k), reqReady0, 1'b0);
      chk($sformatf("stall%0d_ready1", k), reqReady1, 1'b0);
      step();
      chk($sformatf("stall%0d_wrEnable", k), wrEnable, 1'b0);
      chk($sformatf("stall%0d_count", k), conflictCount, 16'd4);
      chk($sformatf("stall%0d_countSat", k), conflictCountS, 2'd3);
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready0", reqReady0, 1'b1);
    chk("unstall_ready1", reqReady1, 1'b0);
    step();
    chk("unstall_wrAddr", wrAddr, 5'd1);
    chk("unstall_count", conflictCount, 16'd5);
    chk("unstall_countSat", conflictCountS, 2'd3);
    chk("unstall2_ready1", reqReady1, 1'b1);
    step();
    chk("unstall2_wrAddr", wrAddr, 5'd2);
    chk("unstall2_count", conflictCount, 16'd6);
    chk("unstall2_countSat", conflictCountS, 2'd3);

    // Move to PREFER1, then reset mid-cycle with a grant pending
    chk("pre_rst_ready0", reqReady0, 1'b1);
    step();
    chk("pre_rst_ready1", reqReady1, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    chk("mid_rst_ready1", reqReady1, 1'b0);
    chk("mid_rst_wrEnable", wrEnable, 1'b0);
    chk("mid_rst_wrAddr", wrAddr, 5'd0);
    chk("mid_rst_wrData", wrData, 64'd0);
    chk("mid_rst_count", conflictCount, 16'd0);
    chk("mid_rst_countSat", conflictCountS, 2'd0);
    step();
    resetN = 1'b1;
    reqValid0 = 1'b0; reqValid1 = 1'b0;
    step();
    chk("post_rst_wrEnable", wrEnable, 1'b0);
    chk("post_rst_wrAddr", wrAddr, 5'd0);
    reqValid0 = 1'b1; reqValid1 = 1'b1;
    #1;
    chk("post_rst_ready0", reqReady0, 1'b1);
    chk("post_rst_ready1", reqReady1, 1'b0);
    reqValid0 = 1'b0; reqValid1 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
